// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK bit serializer.
package bpsk_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData
  } state_e;

endpackage

// File: rtl/sym_edge_detect.sv
// Synchronizes the divided symbol clock and flags its rising edges.
// rise is the combinational edge term; stb is the same pulse registered one cycle later.
module sym_edge_detect
  import bpsk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sym_clk,
  output logic rise,
  output logic stb
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   prev_vld_q;
  logic                   stb_q;

  // vld_q/prev_vld_q mark real samples, so a level already high at reset release
  // is not mistaken for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      vld_q      <= '0;
      prev_q     <= 1'b0;
      prev_vld_q <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sym_clk};
      vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q     <= sync_q[SYNC_STAGES-1];
      prev_vld_q <= vld_q[SYNC_STAGES-1];
      stb_q      <= rise;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & prev_vld_q;
  assign stb  = stb_q;

endmodule

// File: rtl/bpsk_bit_serializer.sv
// Byte-to-symbol serializer for a BPSK modulator: preamble, MSB-first data,
// optional differential phase encoding, all paced by the symbol-rate strobe.
module bpsk_bit_serializer
  import bpsk_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter bit          DIFF_ENC     = 1'b1
) (
  input  logic              I,
  input  logic              RESET_N,
  input  logic              SYM_CLK,
  input  logic [BYTE_W-1:0] DATA,
  input  logic              VALID,
  output logic              READY,
  output logic              TX_BIT,
  output logic              PHASE,
  output logic              SYM_STB,
  output logic              ACTIVE
);

  localparam int unsigned      PRE_W    = $clog2(PREAMBLE_LEN) + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              hold_full_q, hold_full_d;
  logic              ready_q;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tx_bit_q, tx_bit_d;
  logic              phase_q, phase_d;
  logic              rise;
  logic              accept;
  logic              load;

  sym_edge_detect u_sym_edge (
    .clk    (I),
    .rst_n  (RESET_N),
    .sym_clk(SYM_CLK),
    .rise   (rise),
    .stb    (SYM_STB)
  );

  assign accept = VALID & ready_q;

  // FSM acts on the pre-register edge term so TX_BIT/PHASE change alongside SYM_STB.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    tx_bit_d    = tx_bit_q;
    phase_d     = phase_q;
    load        = 1'b0;

    if (rise) begin
      unique case (state_q)
        StIdle: begin
          if (hold_full_q) begin
            state_d   = StPreamble;
            pre_cnt_d = '0;
            tx_bit_d  = 1'b1;
          end else begin
            tx_bit_d = 1'b0;
          end
        end
        StPreamble: begin
          if (pre_cnt_q == PRE_LAST) begin
            load = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
            tx_bit_d  = ~tx_bit_q;
          end
        end
        StData: begin
          if (bit_cnt_q == 3'd7) begin
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d  = StIdle;
              tx_bit_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q << 1;
            tx_bit_d  = shift_q[BYTE_W-2];
          end
        end
        default: state_d = StIdle;
      endcase

      if (load) begin
        state_d     = StData;
        shift_d     = hold_q;
        tx_bit_d    = hold_q[BYTE_W-1];
        hold_full_d = 1'b0;
        bit_cnt_d   = 3'd0;
      end

      // Phase is left alone on the way into idle so the carrier keeps its last sense.
      if (state_d != StIdle) begin
        phase_d = DIFF_ENC ? (phase_q ^ tx_bit_d) : tx_bit_d;
      end
    end

    if (accept) begin
      hold_d      = DATA;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge I or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= 3'd0;
      pre_cnt_q   <= '0;
      tx_bit_q    <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      tx_bit_q    <= tx_bit_d;
      phase_q     <= phase_d;
    end
  end

  assign READY  = ready_q;
  assign TX_BIT = tx_bit_q;
  assign PHASE  = phase_q;
  assign ACTIVE = (state_q != StIdle);

endmodule
